// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock generator: phase state encoding,
// default count width and a small transition helper.
package cpu_clk_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } clk_state_t;

  // True on any transition into a given phase from a different one.
  function automatic logic enters(input clk_state_t cur, input clk_state_t nxt,
                                  input clk_state_t target);
    return (nxt == target) && (cur != target);
  endfunction

endpackage

// File: rtl/cpu_clock_gen_phase_counter.sv
// Half-period down-counter: loads a phase length (0 treated as 1) and flags
// the final cycle of that phase with done.
module phase_counter #(
  parameter int W = cpu_clk_pkg::CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = (value == '0) ? ONE : value;
    end else if (count_reg != '0) begin
      count_next = count_reg - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Count holds the cycles remaining including the current one.
  assign done = (count_reg == ONE);

endmodule

// File: rtl/cpu_clock_gen.sv
// Programmable CPU clock generator: free-running astable or manual
// single-step, with registered level, rise/fall strobes and busy flag.
module cpu_clock_gen #(
  parameter int CNT_W = cpu_clk_pkg::CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_i,
  input  logic             step_i,
  input  logic             halt_i,
  input  logic [CNT_W-1:0] high_cnt_i,
  input  logic [CNT_W-1:0] low_cnt_i,
  output logic             clk_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             busy_o
);

  import cpu_clk_pkg::*;

  clk_state_t       state_reg;
  clk_state_t       state_next;
  logic             rise_reg;
  logic             fall_reg;
  logic             step_q_reg;
  logic             step_armed_reg;
  logic             step_edge;
  logic             phase_load;
  logic             phase_done;
  logic [CNT_W-1:0] phase_value;

  // The armed flag blocks a step level held across reset release from
  // looking like a fresh edge; it arms once step_i has been seen low.
  assign step_edge = step_i & ~step_q_reg & step_armed_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!mode_i && !halt_i) begin
          state_next = HIGH;
        end else if (mode_i && step_edge) begin
          state_next = HIGH;
        end
      end
      HIGH: begin
        if (phase_done) begin
          state_next = LOW;
        end
      end
      LOW: begin
        if (phase_done) begin
          state_next = (mode_i || halt_i) ? IDLE : HIGH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Each phase samples its length exactly once, on entry.
  assign phase_load  = (state_next != state_reg) && (state_next != IDLE);
  assign phase_value = (state_next == HIGH) ? high_cnt_i : low_cnt_i;

  phase_counter #(
    .W (CNT_W)
  ) u_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (phase_load),
    .value (phase_value),
    .done  (phase_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      rise_reg       <= 1'b0;
      fall_reg       <= 1'b0;
      step_q_reg     <= 1'b0;
      step_armed_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rise_reg   <= enters(state_reg, state_next, HIGH);
      fall_reg   <= (state_reg == HIGH) && (state_next == LOW);
      step_q_reg <= step_i;
      if (!step_i) begin
        step_armed_reg <= 1'b1;
      end
    end
  end

  assign clk_o  = (state_reg == HIGH);
  assign rise_o = rise_reg;
  assign fall_o = fall_reg;
  assign busy_o = (state_reg != IDLE);

endmodule
